// File: rtl/uart_lb_pkg.sv
// Shared types and oversampling constants for the UART loopback FIFO block.
package uart_lb_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

endpackage

// File: rtl/uart_lb_fifo.sv
// Synchronous FIFO with occupancy count and a sticky overflow flag for dropped pushes.
module uart_lb_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             do_push, do_pop, ovf_set;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // A pop in the same cycle frees the slot, so a push on full is still accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign ovf_set = push & ~do_push;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
            if (ovf_set)      overflow_q <= 1'b1;
            else if (err_clr) overflow_q <= 1'b0;
        end
    end

    assign rdata    = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_loopback_fifo.sv
// Oversampling UART receiver and transmitter joined by a FIFO; echoes received bytes
// or sends the switches value on a send strobe.
module uart_loopback_fifo
    import uart_lb_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BAUD_DIV   = 326,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rs232_rx,
    output logic                 rs232_tx,
    input  logic [DATA_BITS-1:0] switches,
    input  logic                 send,
    input  logic                 mode,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] leds,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 tx_busy,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int unsigned TICK_W = $clog2(BAUD_DIV + 1);
    localparam int unsigned OS_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_DIV - 1);
    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_MID    = OS_W'(MID_SAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic              rx_meta_q, rx_sync_q;
    logic              send_prev_q;

    rx_state_t            rx_state_q, rx_state_d;
    logic [OS_W-1:0]      rx_os_q, rx_os_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] leds_q, leds_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_valid, frame_err_set;

    tx_state_t            tx_state_q, tx_state_d;
    logic [OS_W-1:0]      tx_os_q, tx_os_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_wdata, fifo_rdata;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_os_d       = rx_os_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        leds_d        = leds_q;
        rx_valid      = 1'b0;
        frame_err_set = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_os_d    = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    rx_os_d = rx_os_q + 1'b1;
                    if (rx_os_q == OS_MID) begin
                        rx_os_d    = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_os_d = rx_os_q + 1'b1;
                    if (rx_os_q == OS_LAST) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_bit_d   = rx_bit_q + 1'b1;
                        if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_os_d = rx_os_q + 1'b1;
                    if (rx_os_q == OS_LAST) begin
                        rx_state_d = RX_IDLE;
                        if (rx_sync_q) begin
                            leds_d   = rx_shift_q;
                            rx_valid = 1'b1;
                        end else begin
                            frame_err_set = 1'b1;
                        end
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        frame_err_d = frame_err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    end

    // Mode only steers which event pushes; frames already in flight are untouched.
    assign fifo_push  = mode ? (send & ~send_prev_q) : rx_valid;
    assign fifo_wdata = mode ? switches : rx_shift_q;

    uart_lb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .wdata    (fifo_wdata),
        .pop      (fifo_pop),
        .err_clr  (err_clr),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        fifo_pop   = 1'b0;
        tx_line    = 1'b1;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tick && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_rdata;
                    tx_os_d    = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tick) begin
                    tx_os_d = tx_os_q + 1'b1;
                    if (tx_os_q == OS_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                tx_line = tx_shift_q[0];
                if (tick) begin
                    tx_os_d = tx_os_q + 1'b1;
                    if (tx_os_q == OS_LAST) begin
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        tx_bit_d   = tx_bit_q + 1'b1;
                        if (tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    tx_os_d = tx_os_q + 1'b1;
                    if (tx_os_q == OS_LAST) begin
                        // Chain straight into the next frame when data is waiting.
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            tx_shift_d = fifo_rdata;
                            tx_state_d = TX_START;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            send_prev_q <= 1'b0;
            rx_state_q  <= RX_IDLE;
            rx_os_q     <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            leds_q      <= '0;
            frame_err_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_os_q     <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
        end else begin
            tick_cnt_q  <= tick ? '0 : tick_cnt_q + 1'b1;
            rx_meta_q   <= rs232_rx;
            rx_sync_q   <= rx_meta_q;
            send_prev_q <= send;
            rx_state_q  <= rx_state_d;
            rx_os_q     <= rx_os_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            leds_q      <= leds_d;
            frame_err_q <= frame_err_d;
            tx_state_q  <= tx_state_d;
            tx_os_q     <= tx_os_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
        end
    end

    assign rs232_tx  = tx_line;
    assign tx_busy   = (tx_state_q != TX_IDLE);
    assign leds      = leds_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed bench: drives serial frames and switch strobes, decodes rs232_tx and checks results.
module tb_uart_loopback_fifo;

    localparam int BIT  = 64;  // 16 ticks x BAUD_DIV=4
    localparam int HALF = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rs232_rx = 1'b1;
    logic       rs232_tx;
    logic [7:0] switches = 8'h00;
    logic       send = 1'b0;
    logic       mode = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] leds;
    logic [2:0] fifo_count;
    logic       tx_busy, overflow, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] tx_q[$];
    int tx_start_q[$];
    int mon_bad = 0;
    bit mon_en = 1'b1;
    logic mon_prev;
    logic [7:0] mon_byte;
    logic mon_ok;
    int mon_st;

    uart_loopback_fifo #(
        .DATA_BITS  (8),
        .BAUD_DIV   (4),
        .FIFO_DEPTH (4),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs232_rx   (rs232_rx),
        .rs232_tx   (rs232_tx),
        .switches   (switches),
        .send       (send),
        .mode       (mode),
        .err_clr    (err_clr),
        .leds       (leds),
        .fifo_count (fifo_count),
        .tx_busy    (tx_busy),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial decoder on rs232_tx, sampling each bit at its centre.
    initial begin
        mon_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && mon_prev && !rs232_tx) begin
                mon_st = cyc;
                mon_ok = 1'b1;
                repeat (HALF) @(negedge clk);
                if (rs232_tx !== 1'b0) mon_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    mon_byte[i] = rs232_tx;
                end
                repeat (BIT) @(negedge clk);
                if (rs232_tx !== 1'b1) mon_ok = 1'b0;
                if (!mon_ok) mon_bad++;
                tx_q.push_back(mon_byte);
                tx_start_q.push_back(mon_st);
                mon_prev = 1'b1;
            end else begin
                mon_prev = rs232_tx;
            end
        end
    end

    // Called at a negedge; stop bit is held stop_val for stop_cycles, then line idles.
    task automatic drive_frame(input logic [7:0] b, input int stop_cycles, input logic stop_val);
        rs232_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rs232_rx = stop_val;
        repeat (stop_cycles) @(negedge clk);
        rs232_rx = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (tx_q.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d frames, expected %0d", name, tx_q.size(), n);
        end
    endtask

    task automatic pulse_send(input logic [7:0] val);
        switches = val;
        send = 1'b1;
        repeat (4) @(negedge clk);
        send = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rs232_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", rs232_tx); end
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL rst_leds: got %h expected 00", leds); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        checks++; if ({tx_busy, overflow, frame_err} !== 3'b000) begin
            errors++; $display("FAIL rst_flags: got %b expected 000", {tx_busy, overflow, frame_err});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL rst_release: got tx=%b busy=%b expected tx=1 busy=0", rs232_tx, tx_busy);
        end
    endtask

    task automatic test_echo;
        int t0;
        logic [7:0] got;
        mode = 1'b0;
        tx_q.delete(); tx_start_q.delete();
        t0 = cyc;
        drive_frame(8'hA5, BIT, 1'b1);
        wait_frames(1, 800, "echo_frame");
        got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL echo_leds: got %h expected a5", leds); end
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL echo_byte: got %h expected a5", got); end
        checks++; if (tx_start_q.size() == 0 || tx_start_q[0] - t0 > 10 * BIT + BIT) begin
            errors++; $display("FAIL echo_latency: got start offset %0d, expected <= %0d",
                               (tx_start_q.size() > 0) ? tx_start_q[0] - t0 : -1, 11 * BIT);
        end
        repeat (BIT) @(negedge clk);
        checks++; if (fifo_count !== 3'd0 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL echo_drain: got count=%0d busy=%b expected 0/0", fifo_count, tx_busy);
        end
        checks++; if (mon_bad != 0) begin errors++; $display("FAIL echo_framing: got %0d bad frames expected 0", mon_bad); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b[3] = '{8'h01, 8'h7E, 8'hFF};
        logic [7:0] got;
        tx_q.delete(); tx_start_q.delete();
        for (int i = 0; i < 3; i++) drive_frame(exp_b[i], BIT, 1'b1);
        wait_frames(3, 2500, "b2b_frames");
        for (int i = 0; i < 3; i++) begin
            got = (tx_q.size() > i) ? tx_q[i] : 8'hxx;
            checks++; if (got !== exp_b[i]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got, exp_b[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++; if (tx_start_q.size() < 3 || tx_start_q[i] - tx_start_q[i-1] != 10 * BIT) begin
                errors++; $display("FAIL b2b_gap%0d: got spacing %0d expected %0d", i,
                                   (tx_start_q.size() > i) ? tx_start_q[i] - tx_start_q[i-1] : -1, 10 * BIT);
            end
        end
        repeat (BIT) @(negedge clk);
        checks++; if (mon_bad != 0) begin errors++; $display("FAIL b2b_framing: got %0d bad frames expected 0", mon_bad); end
    endtask

    task automatic test_mode_switches;
        logic [7:0] got;
        mode = 1'b1;
        tx_q.delete(); tx_start_q.delete();
        switches = 8'h3C;
        fork
            drive_frame(8'h55, BIT, 1'b1);
            begin
                send = 1'b1;
                repeat (100) @(negedge clk);
                send = 1'b0;
            end
        join
        repeat (800) @(negedge clk);
        got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        checks++; if (tx_q.size() != 1) begin errors++; $display("FAIL sw_count: got %0d frames expected 1", tx_q.size()); end
        checks++; if (got !== 8'h3C) begin errors++; $display("FAIL sw_byte: got %h expected 3c", got); end
        checks++; if (leds !== 8'h55) begin errors++; $display("FAIL sw_leds: got %h expected 55", leds); end
    endtask

    task automatic test_frame_err;
        mode = 1'b0;
        tx_q.delete(); tx_start_q.delete();
        drive_frame(8'h12, 48, 1'b0);
        repeat (700) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        checks++; if (leds !== 8'h55) begin errors++; $display("FAIL ferr_leds: got %h expected 55", leds); end
        checks++; if (tx_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL ferr_no_tx: got frames=%0d count=%0d expected 0/0", tx_q.size(), fifo_count);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr: got %b expected 0", frame_err); end
        // Start glitch well short of the mid-bit resample point.
        rs232_rx = 1'b0;
        repeat (24) @(negedge clk);
        rs232_rx = 1'b1;
        repeat (700) @(negedge clk);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_err: got %b expected 0", frame_err); end
        checks++; if (leds !== 8'h55 || tx_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL glitch_byte: got leds=%h frames=%0d count=%0d expected 55/0/0",
                               leds, tx_q.size(), fifo_count);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] vals[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] got;
        mode = 1'b1;
        tx_q.delete(); tx_start_q.delete();
        for (int i = 0; i < 5; i++) pulse_send(vals[i]);
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_full: got count=%0d ovf=%b expected 4/0", fifo_count, overflow);
        end
        pulse_send(vals[5]);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_sat: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b expected 1", tx_busy); end
        wait_frames(5, 5 * 10 * BIT + 800, "ovf_frames");
        repeat (700) @(negedge clk);
        checks++; if (tx_q.size() != 5) begin errors++; $display("FAIL ovf_total: got %0d frames expected 5", tx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (tx_q.size() > i) ? tx_q[i] : 8'hxx;
            checks++; if (got !== vals[i]) begin
                errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, got, vals[i]);
            end
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_mid_frame;
        mon_en = 1'b0;
        mode = 1'b1;
        pulse_send(8'h9A);
        pulse_send(8'hBC);
        repeat (200) @(negedge clk);
        checks++; if (tx_busy !== 1'b1 || fifo_count !== 3'd1) begin
            errors++; $display("FAIL midrst_pre: got busy=%b count=%0d expected 1/1", tx_busy, fifo_count);
        end
        reset = 1'b1;
        #1;
        checks++; if (rs232_tx !== 1'b1 || fifo_count !== 3'd0 || leds !== 8'h00) begin
            errors++; $display("FAIL midrst_assert: got tx=%b count=%0d leds=%h expected 1/0/00",
                               rs232_tx, fifo_count, leds);
        end
        repeat (20) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (rs232_tx !== 1'b1 || fifo_count !== 3'd0 || leds !== 8'h00 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL midrst_release: got tx=%b count=%0d leds=%h busy=%b expected 1/0/00/0",
                               rs232_tx, fifo_count, leds, tx_busy);
        end
        repeat (200) @(negedge clk);
        checks++; if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: got tx=%b busy=%b expected 1/0", rs232_tx, tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_back_to_back();
        test_mode_switches();
        test_frame_err();
        test_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
